fiber_pe_arbiter: RTL and testbench
===================================

Name: fiber_pe_arbiter

Overview:
Upstream stage of a single fiber cache bank. It collects requests from N_PE processing elements and arbitrates among them round-robin. The winner is forwarded to the bank through a registered output slice. For every READ/CONSUME it tracks the requester ID in an in-order FIFO and routes each bank read response back to that PE.

Parameters:
N_PE, 4, number of requesting PEs (power of two, >=2)
DATA_WIDTH, 16, request/response data width
ADDR_WIDTH, 64, request address width
MAX_OUTSTANDING, 8, depth of the requester-ID FIFO (power of two)

Ports:
i_clk  in  1  clock, all state updates on its rising edge
i_nreset  in  1  reset, asynchronous assert, active-low
i_pe_type  in  4*N_PE  per-PE one-hot type: FETCH 0001, READ 0010, WRITE 0100, CONSUME 1000; PE p in slice [4p+:4]
i_pe_addr  in  ADDR_WIDTH*N_PE  per-PE address
i_pe_data  in  DATA_WIDTH*N_PE  per-PE write data, meaningful for WRITE only
i_pe_valid  in  N_PE  per-PE request valid
o_pe_ready  out  N_PE  per-PE request accept; at most one bit high per cycle
o_pe_rdata  out  DATA_WIDTH  response data, broadcast to all PEs
o_pe_rvalid  out  N_PE  per-PE response valid; at most one bit high
i_pe_rready  in  N_PE  per-PE response ready
o_bank_type  out  4  forwarded request type
o_bank_addr  out  ADDR_WIDTH  forwarded address
o_bank_data  out  DATA_WIDTH  forwarded write data
o_bank_valid  out  1  forwarded request valid
i_bank_ready  in  1  bank accepts type, addr and data in the same cycle
i_bank_rdata  in  DATA_WIDTH  bank read response data
i_bank_rvalid  in  1  bank read response valid
o_bank_rready  out  1  response accept to bank
o_outstanding  out  $clog2(MAX_OUTSTANDING)+1  current ID FIFO occupancy
o_err  out  1  sticky protocol-error flag

Behaviour:
- Reset (async, i_nreset=0): o_bank_valid=0, o_bank_type/addr/data=0, FIFO empty, o_outstanding=0, o_err=0, RR pointer=0, o_pe_ready=0, o_pe_rvalid=0. Reset mid-transfer drops the slice contents and all outstanding IDs; there is no replay.
- Slice free = ~o_bank_valid | i_bank_ready.
- Eligible PE p: i_pe_valid[p] is high, and if its type is READ or CONSUME then the FIFO is not full. Fullness is taken from the registered count with no same-cycle pop lookahead.
- Grant: when the slice is free and any PE is eligible, pick the first eligible PE at or after the RR pointer, wrapping modulo N_PE.
  - o_pe_ready[g]=1, combinational in that cycle.
  - Next edge: slice loads the PE's type/addr/data, o_bank_valid=1, RR pointer=g+1 mod N_PE.
  - With no grant the pointer holds.
- Latency: PE handshake at cycle t; request is visible at the bank at t+1. With i_bank_ready held high, throughput is one request per cycle.
- A slice that is held (valid and not ready) keeps all outputs stable.
- ID push: on a grant of READ or CONSUME, push g at the grant edge. FETCH and WRITE are not pushed.
- Illegal type (zero or not one-hot):
  - Still granted and handshaken, so the PE is not stalled.
  - Not loaded into the slice: o_bank_valid goes 0 unless it was already held.
  - Not pushed to the FIFO; o_err is set.
- Response path, combinational:
  - With h = FIFO head and FIFO non-empty: o_pe_rvalid[h]=i_bank_rvalid, o_pe_rdata=i_bank_rdata, o_bank_rready=i_pe_rready[h].
  - Pop on i_bank_rvalid & o_bank_rready.
- Spurious response (i_bank_rvalid with FIFO empty): o_bank_rready=1 so the beat is discarded, o_err is set, no o_pe_rvalid.
- Simultaneous push and pop: count unchanged. Pointers wrap modulo MAX_OUTSTANDING.
- o_err clears only on reset.

Test Plan:
- Single read: PE1 READ addr 0x1230, bank ready=1 → o_pe_ready=0010 same cycle; next cycle o_bank_type=0010, addr 0x1230, o_outstanding=1; bank rvalid rdata 0xBEEF → o_pe_rvalid=0010, rdata 0xBEEF, outstanding=0.
- Fairness: all 4 PEs continuously request WRITE, bank ready=1 → grants 0,1,2,3,0,1 on consecutive cycles, data forwarded intact.
- Backpressure: i_bank_ready=0 for 5 cycles with a loaded slice → outputs stable, o_pe_ready=0000; on ready, the next grant goes to the pointer-following PE.
- FIFO full: 8 READs outstanding, PE0 READ and PE2 WRITE pending → only PE2 granted; after one response pop, PE0 is granted the following cycle.
- In-order routing: READs from PE3 then PE0; responses 0x1111, 0x2222 → 0x1111 on PE3, then 0x2222 on PE0; PE3 rready=0 stalls o_bank_rready.
- Errors and reset: type 0011 from PE2 → handshake, no bank request, o_err=1; spurious rvalid → dropped; i_nreset pulsed low mid-burst → all outputs 0 immediately, o_err=0.

Source files
------------

// File: rtl/fiber_pe_arbiter.sv
// Round-robin front end of one fiber cache bank: arbitrates N_PE request ports into
// a registered bank slice and steers in-order read responses back to their requester.
module fiber_pe_arbiter #(
    parameter int N_PE            = 4,
    parameter int DATA_WIDTH      = 16,
    parameter int ADDR_WIDTH      = 64,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                               i_clk,
    input  logic                               i_nreset,
    input  logic [4*N_PE-1:0]                  i_pe_type,
    input  logic [ADDR_WIDTH*N_PE-1:0]         i_pe_addr,
    input  logic [DATA_WIDTH*N_PE-1:0]         i_pe_data,
    input  logic [N_PE-1:0]                    i_pe_valid,
    output logic [N_PE-1:0]                    o_pe_ready,
    output logic [DATA_WIDTH-1:0]              o_pe_rdata,
    output logic [N_PE-1:0]                    o_pe_rvalid,
    input  logic [N_PE-1:0]                    i_pe_rready,
    output logic [3:0]                         o_bank_type,
    output logic [ADDR_WIDTH-1:0]              o_bank_addr,
    output logic [DATA_WIDTH-1:0]              o_bank_data,
    output logic                               o_bank_valid,
    input  logic                               i_bank_ready,
    input  logic [DATA_WIDTH-1:0]              i_bank_rdata,
    input  logic                               i_bank_rvalid,
    output logic                               o_bank_rready,
    output logic [$clog2(MAX_OUTSTANDING):0]   o_outstanding,
    output logic                               o_err
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; valid never waits on ready, and a held valid keeps its payload stable.

    localparam int PW = (N_PE > 1) ? $clog2(N_PE) : 1;
    localparam int FW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

    logic [PW-1:0]   rr_ptr;
    logic [N_PE-1:0] pe_rd;
    logic [N_PE-1:0] pe_legal;
    logic [N_PE-1:0] eligible;
    logic            slice_free;
    logic            fifo_full;
    logic            fifo_empty;
    logic            grant_found;
    logic [PW-1:0]   grant_idx;
    logic [PW-1:0]   cand;
    logic            grant;
    logic [3:0]      grant_type;
    logic            grant_legal;
    logic            grant_rd;
    logic            push;
    logic            pop;
    logic            spurious;

    logic [PW-1:0]   id_mem [MAX_OUTSTANDING];
    logic [FW-1:0]   wr_ptr;
    logic [FW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [PW-1:0]   head;

    assign fifo_full  = (count == CW'(MAX_OUTSTANDING));
    assign fifo_empty = (count == '0);
    assign slice_free = ~o_bank_valid | i_bank_ready;

    always_comb begin
        pe_rd    = '0;
        pe_legal = '0;
        eligible = '0;
        for (int p = 0; p < N_PE; p++) begin
            pe_rd[p]    = (i_pe_type[4*p +: 4] == 4'b0010) || (i_pe_type[4*p +: 4] == 4'b1000);
            pe_legal[p] = (i_pe_type[4*p +: 4] != 4'b0000) &&
                          ((i_pe_type[4*p +: 4] & (i_pe_type[4*p +: 4] - 4'd1)) == 4'b0000);
            eligible[p] = i_pe_valid[p] && !(pe_rd[p] && fifo_full);
        end
    end

    // First eligible PE at or after the pointer; PW-bit addition wraps modulo N_PE.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < N_PE; k++) begin
            cand = rr_ptr + PW'(k);
            if (!grant_found && eligible[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign grant       = slice_free & grant_found;
    assign grant_type  = i_pe_type[4*int'(grant_idx) +: 4];
    assign grant_legal = pe_legal[grant_idx];
    assign grant_rd    = pe_rd[grant_idx];
    assign o_pe_ready  = (grant && i_nreset) ? (N_PE'(1) << grant_idx) : '0;

    assign head          = id_mem[rd_ptr];
    assign push          = grant & grant_legal & grant_rd;
    assign pop           = i_bank_rvalid & ~fifo_empty & i_pe_rready[head];
    assign spurious      = i_bank_rvalid & fifo_empty;
    assign o_pe_rdata    = i_bank_rdata;
    assign o_pe_rvalid   = (!fifo_empty && i_bank_rvalid) ? (N_PE'(1) << head) : '0;
    assign o_bank_rready = i_nreset & (fifo_empty | i_pe_rready[head]);
    assign o_outstanding = count;

    always_ff @(posedge i_clk or negedge i_nreset) begin
        if (!i_nreset) begin
            o_bank_valid <= 1'b0;
            o_bank_type  <= '0;
            o_bank_addr  <= '0;
            o_bank_data  <= '0;
            rr_ptr       <= '0;
            o_err        <= 1'b0;
        end else begin
            // An illegal grant is consumed here: the slice is free, so it simply empties.
            if (grant && grant_legal) begin
                o_bank_valid <= 1'b1;
                o_bank_type  <= grant_type;
                o_bank_addr  <= i_pe_addr[ADDR_WIDTH*int'(grant_idx) +: ADDR_WIDTH];
                o_bank_data  <= i_pe_data[DATA_WIDTH*int'(grant_idx) +: DATA_WIDTH];
            end else if (i_bank_ready) begin
                o_bank_valid <= 1'b0;
            end
            if (grant) begin
                rr_ptr <= grant_idx + PW'(1);
            end
            if ((grant && !grant_legal) || spurious) begin
                o_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            id_mem[wr_ptr] <= grant_idx;
        end
    end

    always_ff @(posedge i_clk or negedge i_nreset) begin
        if (!i_nreset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + FW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fiber_pe_arbiter.sv
// Randomized and directed bench for fiber_pe_arbiter: a queue/array reference model
// predicts grants, bank requests and routed responses; a negedge monitor checks them.
module tb_fiber_pe_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int AW = 64;
    localparam int M  = 8;
    localparam int CW = 4;

    logic              i_clk;
    logic              i_nreset;
    logic [4*N-1:0]    i_pe_type;
    logic [AW*N-1:0]   i_pe_addr;
    logic [DW*N-1:0]   i_pe_data;
    logic [N-1:0]      i_pe_valid;
    logic [N-1:0]      o_pe_ready;
    logic [DW-1:0]     o_pe_rdata;
    logic [N-1:0]      o_pe_rvalid;
    logic [N-1:0]      i_pe_rready;
    logic [3:0]        o_bank_type;
    logic [AW-1:0]     o_bank_addr;
    logic [DW-1:0]     o_bank_data;
    logic              o_bank_valid;
    logic              i_bank_ready;
    logic [DW-1:0]     i_bank_rdata;
    logic              i_bank_rvalid;
    logic              o_bank_rready;
    logic [CW-1:0]     o_outstanding;
    logic              o_err;

    fiber_pe_arbiter #(.N_PE(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(M)) dut (
        .i_clk(i_clk), .i_nreset(i_nreset),
        .i_pe_type(i_pe_type), .i_pe_addr(i_pe_addr), .i_pe_data(i_pe_data),
        .i_pe_valid(i_pe_valid), .o_pe_ready(o_pe_ready),
        .o_pe_rdata(o_pe_rdata), .o_pe_rvalid(o_pe_rvalid), .i_pe_rready(i_pe_rready),
        .o_bank_type(o_bank_type), .o_bank_addr(o_bank_addr), .o_bank_data(o_bank_data),
        .o_bank_valid(o_bank_valid), .i_bank_ready(i_bank_ready),
        .i_bank_rdata(i_bank_rdata), .i_bank_rvalid(i_bank_rvalid), .o_bank_rready(o_bank_rready),
        .o_outstanding(o_outstanding), .o_err(o_err)
    );

    // ---------------- clock / reset ----------------
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    typedef struct packed {
        logic [N-1:0]  rdy;
        logic [N-1:0]  rvalid;
        logic          brready;
        logic [CW-1:0] outst;
        logic          err;
        logic          bvalid;
    } cyc_exp_t;

    typedef struct packed {
        logic [3:0]    t;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } req_t;

    typedef struct packed {
        logic [N-1:0]  id;
        logic [DW-1:0] d;
    } rsp_t;

    cyc_exp_t cyc_q[$];
    req_t     bank_q[$];
    rsp_t     rsp_q[$];

    // reference model: arbitration pointer, in-order requester list, slice occupancy
    int       rr;
    int       ids[$];
    bit       m_valid;
    bit       m_err;
    bit       beat_open;
    logic [DW-1:0] held_rd;

    int vectors;
    int miscompares;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit is_rd(input logic [3:0] t);
        return (t == 4'b0010) || (t == 4'b1000);
    endfunction

    function automatic bit is_legal(input logic [3:0] t);
        return $countones(t) == 1;
    endfunction

    task automatic model_reset();
        rr = 0;
        ids.delete();
        m_valid   = 0;
        m_err     = 0;
        beat_open = 0;
        cyc_q.delete();
        bank_q.delete();
        rsp_q.delete();
    endtask

    // ---------------- driver ----------------
    // Called at posedge+1: drives one cycle, records expectations, advances the model.
    task automatic step(input logic [N-1:0] v, input logic [4*N-1:0] ty,
                        input logic [AW*N-1:0] ad, input logic [DW*N-1:0] da,
                        input logic br, input logic rv, input logic [DW-1:0] rd,
                        input logic [N-1:0] prr);
        int       g;
        int       h;
        bit       full;
        bit       acc;
        bit       pop_it;
        logic [3:0] t;
        cyc_exp_t e;
        rsp_t     r;
        req_t     q;
        i_pe_valid    = v;
        i_pe_type     = ty;
        i_pe_addr     = ad;
        i_pe_data     = da;
        i_bank_ready  = br;
        i_bank_rvalid = rv;
        i_bank_rdata  = rd;
        i_pe_rready   = prr;
        if (rv) held_rd = rd;

        full = (ids.size() == M);
        g = -1;
        if (!m_valid || br) begin
            for (int k = 0; k < N; k++) begin
                t = ty[4*((rr + k) % N) +: 4];
                if (g < 0 && v[(rr + k) % N] && !(is_rd(t) && full)) g = (rr + k) % N;
            end
        end
        e.rdy    = (g >= 0) ? (N'(1) << g) : '0;
        e.outst  = CW'(ids.size());
        e.err    = m_err;
        e.bvalid = m_valid;
        pop_it   = 0;
        if (ids.size() > 0) begin
            h         = ids[0];
            e.rvalid  = rv ? (N'(1) << h) : '0;
            e.brready = prr[h];
            acc       = rv && prr[h];
            pop_it    = acc;
            if (rv && !beat_open) begin
                r.id = N'(1) << h;
                r.d  = rd;
                rsp_q.push_back(r);
            end
        end else begin
            e.rvalid  = '0;
            e.brready = 1'b1;
            acc       = rv;
            if (rv) m_err = 1;
        end
        cyc_q.push_back(e);
        beat_open = rv && !acc;

        if (m_valid && br) m_valid = 0;
        if (pop_it) void'(ids.pop_front());
        if (g >= 0) begin
            t  = ty[4*g +: 4];
            rr = (g + 1) % N;
            if (is_legal(t)) begin
                m_valid = 1;
                q.t = t;
                q.a = ad[AW*g +: AW];
                q.d = da[DW*g +: DW];
                bank_q.push_back(q);
                if (is_rd(t)) ids.push_back(g);
            end else begin
                m_err = 1;
            end
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, '0, '0, '0, 1'b1, 1'b0, '0, '1);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && ids.size() > 0; i++)
            step('0, '0, '0, '0, 1'b1, 1'b1, DW'($urandom), '1);
        idle(2);
    endtask

    task automatic rand_cycle(input int rv_pct, input int br_pct);
        logic [4*N-1:0]  ty;
        logic [AW*N-1:0] ad;
        logic [DW*N-1:0] da;
        logic            rv;
        logic [DW-1:0]   rd;
        int              s;
        for (int p = 0; p < N; p++) begin
            s = $urandom_range(0, 39);
            if (s < 10)      ty[4*p +: 4] = 4'b0001;
            else if (s < 20) ty[4*p +: 4] = 4'b0010;
            else if (s < 29) ty[4*p +: 4] = 4'b0100;
            else if (s < 38) ty[4*p +: 4] = 4'b1000;
            else if (s < 39) ty[4*p +: 4] = 4'b0110;
            else             ty[4*p +: 4] = 4'b0000;
            ad[AW*p +: AW] = {$urandom, $urandom};
            da[DW*p +: DW] = DW'($urandom);
        end
        if (beat_open) begin
            rv = 1'b1;
            rd = held_rd;
        end else begin
            rv = ($urandom_range(0, 99) < rv_pct);
            rd = DW'($urandom);
        end
        step(N'($urandom), ty, ad, da, ($urandom_range(0, 99) < br_pct), rv, rd, N'($urandom));
    endtask

    // ---------------- monitor ----------------
    always @(negedge i_clk) begin
        cyc_exp_t e;
        req_t     q;
        if (cyc_q.size() > 0) begin
            e = cyc_q.pop_front();
            chk("pe_ready", 64'(o_pe_ready), 64'(e.rdy));
            chk("pe_rvalid", 64'(o_pe_rvalid), 64'(e.rvalid));
            chk("bank_rready", 64'(o_bank_rready), 64'(e.brready));
            chk("outstanding", 64'(o_outstanding), 64'(e.outst));
            chk("err", 64'(o_err), 64'(e.err));
            chk("bank_valid", 64'(o_bank_valid), 64'(e.bvalid));
            if (o_bank_valid && i_bank_ready) begin
                if (bank_q.size() == 0) begin
                    chk("bank_req_unexpected", 64'(1), 64'(0));
                end else begin
                    q = bank_q.pop_front();
                    chk("bank_type", 64'(o_bank_type), 64'(q.t));
                    chk("bank_addr", o_bank_addr, q.a);
                    chk("bank_data", 64'(o_bank_data), 64'(q.d));
                end
            end
            if (o_pe_rvalid != '0) begin
                if (rsp_q.size() == 0) begin
                    chk("rsp_unexpected", 64'(1), 64'(0));
                end else begin
                    chk("rsp_id", 64'(o_pe_rvalid), 64'(rsp_q[0].id));
                    chk("rsp_data", 64'(o_pe_rdata), 64'(rsp_q[0].d));
                    if ((o_pe_rvalid & i_pe_rready) != '0) void'(rsp_q.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [4*N-1:0]  ty;
        logic [AW*N-1:0] ad;
        logic [DW*N-1:0] da;
        vectors     = 0;
        miscompares = 0;
        held_rd     = '0;
        model_reset();
        i_nreset      = 1'b0;
        i_pe_valid    = '0;
        i_pe_type     = '0;
        i_pe_addr     = '0;
        i_pe_data     = '0;
        i_bank_ready  = 1'b0;
        i_bank_rvalid = 1'b0;
        i_bank_rdata  = '0;
        i_pe_rready   = '0;
        #12;
        chk("rst_bank_valid", 64'(o_bank_valid), 64'(0));
        chk("rst_outstanding", 64'(o_outstanding), 64'(0));
        chk("rst_err", 64'(o_err), 64'(0));
        @(negedge i_clk);
        i_nreset = 1'b1;
        @(posedge i_clk);
        #1;

        // single read from PE1, answered with 0xBEEF
        ty = '0; ad = '0; da = '0;
        ty[4*1 +: 4] = 4'b0010;
        ad[AW*1 +: AW] = 64'h1230;
        step(4'b0010, ty, ad, da, 1'b1, 1'b0, '0, '1);
        idle(1);
        step('0, '0, '0, '0, 1'b1, 1'b1, 16'hBEEF, '1);
        idle(1);

        // fairness: everyone requests WRITE continuously
        for (int p = 0; p < N; p++) begin
            ty[4*p +: 4] = 4'b0100;
            ad[AW*p +: AW] = 64'h1000 + 64'(p);
        end
        for (int i = 0; i < 6; i++) begin
            for (int p = 0; p < N; p++) da[DW*p +: DW] = DW'($urandom);
            step(4'b1111, ty, ad, da, 1'b1, 1'b0, '0, '1);
        end
        // backpressure for 5 cycles with the slice loaded, then release
        for (int i = 0; i < 5; i++) step(4'b1111, ty, ad, da, 1'b0, 1'b0, '0, '1);
        step(4'b1111, ty, ad, da, 1'b1, 1'b0, '0, '1);
        idle(2);

        // fill the ID FIFO with PE0 reads, then PE0 READ vs PE2 WRITE
        ty = '0;
        ty[4*0 +: 4] = 4'b0010;
        ty[4*2 +: 4] = 4'b0100;
        for (int i = 0; i < M; i++) step(4'b0001, ty, ad, da, 1'b1, 1'b0, '0, '1);
        step(4'b0101, ty, ad, da, 1'b1, 1'b0, '0, '1);
        step(4'b0101, ty, ad, da, 1'b1, 1'b1, 16'h5A5A, '1);
        step(4'b0101, ty, ad, da, 1'b1, 1'b0, '0, '1);
        drain();

        // in-order routing PE3 then PE0, PE3 stalls its response twice
        ty = '0;
        ty[4*3 +: 4] = 4'b0010;
        step(4'b1000, ty, ad, da, 1'b1, 1'b0, '0, '1);
        ty = '0;
        ty[4*0 +: 4] = 4'b1000;
        step(4'b0001, ty, ad, da, 1'b1, 1'b0, '0, '1);
        step('0, '0, '0, '0, 1'b1, 1'b1, 16'h1111, 4'b0111);
        step('0, '0, '0, '0, 1'b1, 1'b1, 16'h1111, 4'b0111);
        step('0, '0, '0, '0, 1'b1, 1'b1, 16'h1111, 4'b1111);
        step('0, '0, '0, '0, 1'b1, 1'b1, 16'h2222, 4'b1111);
        idle(1);

        // illegal type from PE2, then a spurious response
        ty = '0;
        ty[4*2 +: 4] = 4'b0011;
        step(4'b0100, ty, ad, da, 1'b1, 1'b0, '0, '1);
        idle(1);
        step('0, '0, '0, '0, 1'b1, 1'b1, 16'hDEAD, '1);
        idle(2);

        // randomized traffic: read-heavy with scarce responses, then balanced
        for (int i = 0; i < 1500; i++) rand_cycle(10, 70);
        for (int i = 0; i < 1500; i++) rand_cycle(60, 80);

        // reset pulsed mid-burst
        for (int i = 0; i < 20; i++) rand_cycle(20, 90);
        for (int p = 0; p < N; p++) ty[4*p +: 4] = 4'b0100;
        step(4'b1111, ty, ad, da, 1'b1, 1'b0, '0, '1);
        i_pe_valid = 4'b1111;
        #2;
        i_nreset = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_pe_ready", 64'(o_pe_ready), 64'(0));
        chk("mid_rst_pe_rvalid", 64'(o_pe_rvalid), 64'(0));
        chk("mid_rst_bank_valid", 64'(o_bank_valid), 64'(0));
        chk("mid_rst_bank_addr", o_bank_addr, 64'(0));
        chk("mid_rst_bank_type", 64'(o_bank_type), 64'(0));
        chk("mid_rst_outstanding", 64'(o_outstanding), 64'(0));
        chk("mid_rst_err", 64'(o_err), 64'(0));
        chk("mid_rst_bank_rready", 64'(o_bank_rready), 64'(0));
        i_pe_valid    = '0;
        i_bank_rvalid = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        i_nreset = 1'b1;
        @(posedge i_clk);
        #1;

        for (int i = 0; i < 1000; i++) rand_cycle(40, 75);
        while (beat_open) rand_cycle(0, 100);
        drain();
        idle(3);
        chk("bank_q_empty", 64'(bank_q.size()), 64'(0));
        chk("rsp_q_empty", 64'(rsp_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
